// File: rtl/nport_ram_pkg.sv
// nport_ram_pkg: shared types and lane helpers for the n-port byte-enable RAM
package nport_ram_pkg;
  localparam int MAX_DW = 256;
  typedef enum logic {IDLE, CLEAR} state_t;
  function automatic int num_lanes(input int dw, input int lw);
    return dw / lw;
  endfunction
  // Operands are zero-extended to MAX_DW; callers size-cast the result back.
  function automatic logic [MAX_DW-1:0] lane_merge(input logic [MAX_DW-1:0] old_w, input logic [MAX_DW-1:0] new_w, input logic [MAX_DW-1:0] be, input int lw);
    logic [MAX_DW-1:0] m;
    for (int i = 0; i < MAX_DW; i++) m[i] = be[i / lw] ? new_w[i] : old_w[i];
    return m;
  endfunction
endpackage

// File: rtl/nport_ram_be_if.sv
// nport_ram_be_if: write, read and clear-control bundle of the n-port RAM
interface nport_ram_be_if import nport_ram_pkg::*; #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LANE_WIDTH = 8,
  parameter int NUM_RD = 2
) ();
  localparam int NUM_LANES = num_lanes(DATA_WIDTH, LANE_WIDTH);
  logic clr_req;
  logic busy;
  logic we;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [NUM_LANES-1:0] write_be;
  logic wr_drop;
  logic [NUM_RD-1:0] rd_en;
  logic [NUM_RD*ADDR_WIDTH-1:0] read_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] read_data;
  logic [NUM_RD-1:0] rd_valid;
  modport master (output clr_req, we, write_addr, write_data, write_be, rd_en, read_addr, input busy, wr_drop, read_data, rd_valid);
  modport slave (input clr_req, we, write_addr, write_data, write_be, rd_en, read_addr, output busy, wr_drop, read_data, rd_valid);
endinterface

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: sweeps every word to the init value after reset or on request
module ram_clear_seq import nport_ram_pkg::*; #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_req,
  output logic busy,
  output logic clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);
  localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic last;
  always_comb begin
    last = ptr_q == LAST;
    state_d = (state_q == CLEAR) ? (last ? IDLE : CLEAR) : (clr_req ? CLEAR : IDLE);
    ptr_d = (state_q == CLEAR) ? (last ? ptr_q : ptr_q + ADDR_WIDTH'(1)) : (clr_req ? '0 : ptr_q);
    busy = state_q == CLEAR;
    clr_we = busy & rst_n;
    clr_addr = ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/nport_ram_be.sv
// nport_ram_be: N registered read ports, one byte-enabled write port, write-first bypass, clear sweep
module nport_ram_be import nport_ram_pkg::*; #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LANE_WIDTH = 8,
  parameter int NUM_RD = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic clk,
  input logic rst_n,
  nport_ram_be_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic busy, clr_we, wr_acc, mem_we, wr_drop_d, wr_drop_q;
  logic [ADDR_WIDTH-1:0] clr_addr, mem_addr;
  logic [DATA_WIDTH-1:0] wr_word, mem_wdata;
  ram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr (
    .clk(clk),
    .rst_n(rst_n),
    .clr_req(bus.clr_req),
    .busy(busy),
    .clr_we(clr_we),
    .clr_addr(clr_addr)
  );
  // wr_word is the post-write word; reads of the write address reuse it as the bypass value
  always_comb begin
    wr_acc = bus.we & ~busy;
    wr_word = DATA_WIDTH'(lane_merge(MAX_DW'(mem[bus.write_addr]), MAX_DW'(bus.write_data), MAX_DW'(bus.write_be), LANE_WIDTH));
    mem_we = clr_we | wr_acc;
    mem_addr = clr_we ? clr_addr : bus.write_addr;
    mem_wdata = clr_we ? INIT_VALUE : wr_word;
    wr_drop_d = bus.we & busy;
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) wr_drop_q <= 1'b0;
    else wr_drop_q <= wr_drop_d;
  end
  assign bus.busy = busy;
  assign bus.wr_drop = wr_drop_q;
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic valid_d, valid_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;
    always_comb begin
      ra = bus.read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      valid_d = bus.rd_en[p] & ~busy;
      data_d = !valid_d ? data_q : (wr_acc && bus.write_addr == ra) ? wr_word : mem[ra];
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q <= '0;
      end else begin
        valid_q <= valid_d;
        data_q <= data_d;
      end
    end
    assign bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign bus.rd_valid[p] = valid_q;
  end
endmodule

// File: doc/nport_ram_be.md
Name: nport_ram_be

Overview:
Parametrised successor to the team's dual-port RAM. Adds:
- N registered read ports.
- One write port with per-lane byte enables.
- Write-first bypass.
- A hardware clear sequencer that sweeps the whole array to a fixed value after reset or on request.

Used as the shared buffer or register store between datapath stages. Reads stay deterministic after reset; there is no dependence on simulator initial contents.

Parameters:
- ADDR_WIDTH, 12, address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, write-enable granularity; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- NUM_RD, 2, number of read ports (1..8).
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word by the clear sweep.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  reset, synchronous and active-low; one clock, reset is synchronous and active-low.
- clr_req  in  1  pulse; starts a clear sweep when idle.
- busy  out  1  high while the clear sweep is pending or running.
- we  in  1  write strobe.
- write_addr  in  ADDR_WIDTH  write address.
- write_data  in  DATA_WIDTH  write data.
- write_be  in  NUM_LANES  per-lane write enable; bit i covers data[i*LANE_WIDTH +: LANE_WIDTH].
- wr_drop  out  1  one-cycle pulse: a write with we=1 was discarded because busy=1.
- rd_en  in  NUM_RD  per-port read request.
- read_addr  in  NUM_RD*ADDR_WIDTH  port p address at [p*ADDR_WIDTH +: ADDR_WIDTH].
- read_data  out  NUM_RD*DATA_WIDTH  port p data at [p*DATA_WIDTH +: DATA_WIDTH].
- rd_valid  out  NUM_RD  port p data valid, one cycle after an accepted rd_en.

Behaviour:
- Reset (rst_n=0 at posedge): read_data=0, rd_valid=0, wr_drop=0, busy=1, clear pointer=0, FSM=CLEAR. Array contents are not touched during reset.
- FSM states and transitions:
  - CLEAR: each cycle writes INIT_VALUE to all lanes of word ptr, then ptr++. When ptr==DEPTH-1 is written, go to IDLE next cycle.
  - Sweep length is exactly DEPTH cycles after rst_n rises; busy falls on the cycle after the last write.
  - IDLE: clr_req=1 sets ptr=0 and goes to CLEAR, with busy=1 from the next cycle.
- Clear pointer: ADDR_WIDTH bits; terminal compare against DEPTH-1, no wrap past it.
- clr_req while CLEAR: ignored; the sweep does not restart.
- Reset mid-sweep: restarts the sweep from ptr=0.
- Writes, busy=0: at posedge, lanes with write_be[i]=1 are updated; other lanes keep their old value. we=1 with write_be=0 is a no-op.
- Writes, busy=1: discarded; wr_drop=1 next cycle iff we=1.
- Reads: accepted iff rd_en[p]=1 and busy=0.
  - Latency 1: read_data[p] and rd_valid[p]=1 are registered at the posedge that samples the request.
  - When not accepted: rd_valid[p]=0 and read_data[p] holds its last value.
- Write-first bypass: same-cycle accepted write and read to the same address return the new data for enabled lanes and old array data for disabled lanes, per port independently.
- Multiple ports may read the same address in the same cycle; all receive identical data.
- Request on the last sweep cycle (busy=1): rejected. Request on the first cycle with busy=0: accepted and returns INIT_VALUE unless overwritten.
- No combinational path from any input to any output.

Decomposition:
- Package nport_ram_pkg:
  - FSM state enum {IDLE, CLEAR}, 1 bit.
  - Function num_lanes(DATA_WIDTH, LANE_WIDTH).
  - Lane-merge function (old, new, be) -> merged word, used by both the write path and the bypass.
- Sub-module ram_clear_seq:
  - Owns FSM, ptr and busy.
  - Outputs clr_we and clr_addr, muxed ahead of the user write port.
- Top level: array, write mux, NUM_RD read pipelines generated by loop.

Test Plan:
(Bench uses ADDR_WIDTH=4, DATA_WIDTH=32, LANE_WIDTH=8, NUM_RD=2, INIT_VALUE=32'hA5A5A5A5.)
- Hold rst_n=0 for 3 cycles, release -> busy=1 for exactly 16 cycles then 0. Reading addr 0..15 on both ports returns A5A5A5A5 with rd_valid one cycle later.
- Write during sweep, addr 3 data 1234_5678 -> wr_drop pulses once. After busy=0, addr 3 reads A5A5A5A5.
- Write addr 5 = 1122_3344 with be=4'hF, then addr 5 = FFFF_FFFF with be=4'b0101 -> next read returns 11FF_33FF.
- Same-cycle write addr 7 = DEAD_BEEF with be=4'b1100 while port0 and port1 both read addr 7 (old value A5A5A5A5) -> both return DEADA5A5 next cycle.
- clr_req at cycle 100, second clr_req at cycle 105 -> one 16-cycle sweep only. rd_en during the sweep gives rd_valid=0 and read_data unchanged. All words equal A5A5A5A5 afterwards.
- rst_n=0 at sweep ptr=9 -> after release busy=1 for a full 16 cycles and all words read back as A5A5A5A5.
